// File: rtl/bus_ctrl_pkg.sv
// Shared state encoding and default sizing for the data bus controller.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } bus_state_t;

  localparam int DEF_NUM_SOURCES    = 4;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_WAIT_WIDTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-wins encoder over a request vector, with a valid flag.
// Latency: combinational.
// Backpressure: none.
module priority_encoder #(
  parameter  int WIDTH = 4,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_bus_controller.sv
// Steers CPU bus cycles to the lowest-index claiming source, or to the external bus.
// Latency: ready returns W+1 cycles after command start when the source is ready.
// Backpressure: processor_ready held low until wait states, source_ready or timeout.
module data_bus_controller
  import bus_ctrl_pkg::*;
#(
  parameter  int                    NUM_SOURCES    = DEF_NUM_SOURCES,
  parameter  int                    DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter  int                    WAIT_WIDTH     = DEF_WAIT_WIDTH,
  parameter  int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  logic [DATA_WIDTH-1:0] IDLE_DATA      = '1,
  localparam int                    SRC_W          = $clog2(NUM_SOURCES),
  localparam int                    TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              io_read_n,
  input  logic                              io_write_n,
  input  logic                              memory_read_n,
  input  logic                              memory_write_n,
  input  logic [NUM_SOURCES-1:0]            source_select,
  input  logic [NUM_SOURCES-1:0]            source_ready,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] source_data,
  input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] source_wait_states,
  input  logic [DATA_WIDTH-1:0]             data_bus_ext,
  output logic [DATA_WIDTH-1:0]             data_bus_out,
  output logic                              data_bus_direction,
  output logic                              processor_ready,
  output logic [SRC_W-1:0]                  active_source,
  output logic                              bus_timeout
);

  bus_state_t            state_q, state_d;
  logic                  prev_cmd_q, armed_q, armed_d, is_read_q, is_read_d;
  logic [WAIT_WIDTH-1:0] wait_q, wait_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [SRC_W-1:0]      src_d, enc_idx;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  dir_d, rdy_d, tmo_d, enc_vld;
  logic                  cmd, rd, start;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [WAIT_WIDTH-1:0] enc_wait;

  assign cmd = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
  assign rd  = ~io_read_n | ~memory_read_n;
  // armed_q blocks a strobe that was already active when reset released.
  assign start = cmd & ~prev_cmd_q & armed_q;
  assign armed_d = armed_q | ~cmd;

  assign sel_data = source_data[int'(active_source)*DATA_WIDTH +: DATA_WIDTH];
  assign enc_wait = source_wait_states[int'(enc_idx)*WAIT_WIDTH +: WAIT_WIDTH];

  priority_encoder #(.WIDTH(NUM_SOURCES)) u_prio (
    .req (source_select),
    .idx (enc_idx),
    .vld (enc_vld)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    to_d      = to_q;
    src_d     = active_source;
    dout_d    = data_bus_out;
    dir_d     = data_bus_direction;
    rdy_d     = processor_ready;
    tmo_d     = 1'b0;
    is_read_d = is_read_q;
    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        dir_d = 1'b0;
        if (start) begin
          is_read_d = rd;
          if (enc_vld) begin
            src_d   = enc_idx;
            wait_d  = enc_wait;
            to_d    = '0;
            rdy_d   = 1'b0;
            state_d = ST_WAIT;
          end else begin
            dir_d   = 1'b1;
            state_d = ST_HOLD;
            if (rd) dout_d = data_bus_ext;
          end
        end
      end
      ST_WAIT: begin
        if (!cmd) begin
          rdy_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_q == '0 && source_ready[active_source]) begin
          if (is_read_q) dout_d = sel_data;
          rdy_d   = 1'b1;
          state_d = ST_HOLD;
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the last allowed WAIT cycle; terminate with filler data.
          if (is_read_q) dout_d = IDLE_DATA;
          tmo_d   = 1'b1;
          rdy_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          wait_d = (wait_q == '0) ? '0 : wait_q - WAIT_WIDTH'(1);
          to_d   = to_q + TO_W'(1);
        end
      end
      ST_HOLD: begin
        if (!cmd) begin
          dir_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (data_bus_direction && is_read_q) begin
          dout_d = data_bus_ext;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      prev_cmd_q         <= 1'b0;
      armed_q            <= 1'b0;
      is_read_q          <= 1'b0;
      wait_q             <= '0;
      to_q               <= '0;
      active_source      <= '0;
      data_bus_out       <= '0;
      data_bus_direction <= 1'b0;
      processor_ready    <= 1'b1;
      bus_timeout        <= 1'b0;
    end else begin
      state_q            <= state_d;
      prev_cmd_q         <= cmd;
      armed_q            <= armed_d;
      is_read_q          <= is_read_d;
      wait_q             <= wait_d;
      to_q               <= to_d;
      active_source      <= src_d;
      data_bus_out       <= dout_d;
      data_bus_direction <= dir_d;
      processor_ready    <= rdy_d;
      bus_timeout        <= tmo_d;
    end
  end

endmodule

// File: tb/tb_data_bus_controller.sv
// Randomized and directed bench for data_bus_controller against a transaction-level model.
module tb_data_bus_controller;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int WW = 4;
  localparam int TO = 64;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_read_n, io_write_n, memory_read_n, memory_write_n;
  logic [NS-1:0]    source_select, source_ready;
  logic [NS*DW-1:0] source_data;
  logic [NS*WW-1:0] source_wait_states;
  logic [DW-1:0]    data_bus_ext, data_bus_out;
  logic             data_bus_direction, processor_ready, bus_timeout;
  logic [1:0]       active_source;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_dout;

  always #5 clock = ~clock;

  data_bus_controller #(
    .NUM_SOURCES(NS), .DATA_WIDTH(DW), .WAIT_WIDTH(WW), .TIMEOUT_CYCLES(TO), .IDLE_DATA(8'hFF)
  ) dut (
    .clock(clock), .reset(reset),
    .io_read_n(io_read_n), .io_write_n(io_write_n),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .source_select(source_select), .source_ready(source_ready),
    .source_data(source_data), .source_wait_states(source_wait_states),
    .data_bus_ext(data_bus_ext), .data_bus_out(data_bus_out),
    .data_bus_direction(data_bus_direction), .processor_ready(processor_ready),
    .active_source(active_source), .bus_timeout(bus_timeout)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 io read, 1 io write, 2 memory read, 3 memory write
  task automatic set_strobes(input int kind);
    io_read_n      = !(kind == 0);
    io_write_n     = !(kind == 1);
    memory_read_n  = !(kind == 2);
    memory_write_n = !(kind == 3);
  endtask

  task automatic release_strobes();
    io_read_n = 1'b1; io_write_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1;
  endtask

  // r_at: first WAIT cycle (1-based) at which the owning source reports ready.
  task automatic run_txn(input logic [3:0] sel, input logic [15:0] waits, input int r_at,
                         input int kind, input int abort_in, input int hold_len,
                         input logic [7:0] ext_val);
    int idx, w, kc, exp_lows, lows, tmo_seen, abort_k;
    bit ext, is_rd, tmo_exp, done;
    logic [31:0] sdata;

    idx = -1;
    for (int i = 3; i >= 0; i--) if (sel[i]) idx = i;
    ext     = (idx < 0);
    is_rd   = (kind == 0 || kind == 2);
    tmo_exp = 1'b0;
    kc      = 0;
    if (!ext) begin
      w  = int'(waits[idx*4 +: 4]);
      kc = (w + 1 > r_at) ? w + 1 : r_at;
      if (kc > TO) begin
        kc      = TO;
        tmo_exp = 1'b1;
      end
    end
    abort_k = (!ext && abort_in > 0 && abort_in < kc) ? abort_in : 0;
    sdata   = $urandom;

    exp_lows = (abort_k != 0) ? abort_k : kc;
    if (abort_k == 0 && is_rd) begin
      if (ext)          exp_dout = ext_val;
      else if (tmo_exp) exp_dout = 8'hFF;
      else              exp_dout = sdata[idx*8 +: 8];
    end

    @(negedge clock);
    source_select      = sel;
    source_wait_states = waits;
    source_data        = sdata;
    data_bus_ext       = ext_val;
    source_ready       = 4'($urandom);
    if (!ext) source_ready[idx] = (r_at <= 0);
    set_strobes(kind);

    lows = 0; tmo_seen = 0; done = 1'b0;
    for (int k = 1; k <= 100 && !done; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check_val("direction", 32'(data_bus_direction), 32'(ext));
        if (!ext) check_val("active_source", 32'(active_source), idx);
      end
      if (bus_timeout) tmo_seen++;
      if (processor_ready) done = 1'b1;
      else lows++;
      // Scramble inputs the controller must ignore once the cycle has started.
      source_ready = 4'($urandom);
      if (!ext) source_ready[idx] = (k >= r_at);
      source_select      = 4'($urandom);
      source_wait_states = 16'($urandom);
      if (k == abort_k) release_strobes();
    end
    check_val("ready_low_cycles", lows, exp_lows);
    check_val("data_at_ready", 32'(data_bus_out), 32'(exp_dout));
    check_val("timeout_pulse", tmo_seen, 32'(tmo_exp && abort_k == 0));

    if (abort_k == 0) begin
      for (int h = 0; h < hold_len; h++) begin
        data_bus_ext = 8'($urandom);
        if (ext && is_rd) exp_dout = data_bus_ext;
        @(negedge clock);
        check_val("hold_data", 32'(data_bus_out), 32'(exp_dout));
        check_val("hold_ready", 32'(processor_ready), 1);
        check_val("hold_no_timeout", 32'(bus_timeout), 0);
      end
    end
    release_strobes();
    @(negedge clock);
    check_val("idle_direction", 32'(data_bus_direction), 0);
    check_val("idle_ready", 32'(processor_ready), 1);
    check_val("idle_data", 32'(data_bus_out), 32'(exp_dout));
    check_val("idle_no_timeout", 32'(bus_timeout), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_ready"}, 32'(processor_ready), 1);
    check_val({tag, "_dout"}, 32'(data_bus_out), 0);
    check_val({tag, "_dir"}, 32'(data_bus_direction), 0);
    check_val({tag, "_src"}, 32'(active_source), 0);
    check_val({tag, "_tmo"}, 32'(bus_timeout), 0);
  endtask

  initial begin
    reset = 1'b1;
    release_strobes();
    source_select = '0; source_ready = '0; source_data = '0;
    source_wait_states = '0; data_bus_ext = '0;
    exp_dout = '0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clock);

    run_txn(4'b0100, 16'h0300, 0, 2, 0, 2, 8'h00);    // wait 3 -> 4 low cycles
    run_txn(4'b0110, 16'h0000, 0, 0, 0, 1, 8'h00);    // lowest of two, no waits
    run_txn(4'b0000, 16'hFFFF, 0, 0, 0, 3, 8'h5A);    // external bus read
    run_txn(4'b0001, 16'h0002, 1000, 2, 0, 2, 8'h00); // never ready -> timeout
    run_txn(4'b0001, 16'h0005, 0, 2, 3, 0, 8'h00);    // abort during WAIT
    run_txn(4'b1000, 16'h2000, 5, 3, 0, 1, 8'h00);    // write leaves data alone
    run_txn(4'b0000, 16'h0000, 0, 1, 0, 2, 8'hC3);    // external write

    for (int t = 0; t < 40; t++) begin
      int r_at, ab;
      r_at = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 20));
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0;
      run_txn(4'($urandom), 16'($urandom), r_at, int'($urandom_range(0, 3)), ab,
              int'($urandom_range(1, 3)), 8'($urandom));
    end

    // Reset in the middle of WAIT, with the strobe still active afterwards.
    @(negedge clock);
    source_select = 4'b0010; source_wait_states = 16'h0000; source_ready = '0;
    memory_read_n = 1'b0;
    repeat (5) @(negedge clock);
    check_val("wait_before_reset", 32'(processor_ready), 0);
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("mid_wait_reset");
    exp_dout = '0;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_val("stale_cmd_ignored", 32'(processor_ready), 1);
    end
    release_strobes();
    @(negedge clock);
    memory_read_n = 1'b0;
    @(negedge clock);
    check_val("rearmed_start", 32'(processor_ready), 0);
    release_strobes();
    @(negedge clock);
    check_val("rearmed_abort", 32'(processor_ready), 1);
    check_val("rearmed_no_tmo", 32'(bus_timeout), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
